store_lane_buffer: RTL and testbench

Parametrised store path between the MEM stage and data memory. It positions store data into byte lanes and generates byte enables for byte, halfword and word stores at any offset. Stores that cross a word boundary are either split into two aligned beats or rejected with an error pulse. Beats are queued in a small FIFO with valid/ready handshakes on both sides, so a memory that is not ready stalls the pipeline instead of dropping stores.

---
 rtl/store_lane_buffer_if.sv | 31 +++
 rtl/store_lane_buffer.sv | 142 ++++++++++++++
 tb/tb_store_lane_buffer.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_lane_buffer_if.sv
// Store request port and memory beat port of store_lane_buffer.
// master = pipeline/memory side, slave = the buffer itself.
interface store_lane_buffer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic [DATA_W-1:0] req_data;
  logic              req_err;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NB-1:0]     mem_be;

  modport master (
    output req_valid, req_addr, req_size, req_data, mem_ready,
    input  req_ready, req_err, mem_valid, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_data, mem_ready,
    output req_ready, req_err, mem_valid, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/store_lane_buffer.sv
// Store lane buffer: byte-lane positioning, split/reject of word-crossing stores,
// FIFO of beats to memory; mem_valid the cycle after acceptance, req_ready drops when full or in HIGH.
module store_lane_buffer #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int DEPTH          = 4,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input logic                clk,
  input logic                reset,
  store_lane_buffer_if.slave bus
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [2:0]       MAX_SIZE = 3'(OFF_W);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {IDLE, HIGH} state_t;
  state_t state, state_nxt;

  logic [OFF_W-1:0]    off;
  logic [NB-1:0]       lane_m;
  logic [DATA_W-1:0]   d;
  logic [2*DATA_W-1:0] s_wide;
  logic [2*NB-1:0]     e_wide;
  logic [ADDR_W-1:0]   lo_addr, hi_addr;
  logic                need_high, reject;

  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_wdata;
  logic [NB-1:0]     hold_be;

  logic [ADDR_W-1:0] fifo_addr  [DEPTH];
  logic [DATA_W-1:0] fifo_wdata [DEPTH];
  logic [NB-1:0]     fifo_be    [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              full, req_rdy, acc, pop, push, push_hold, hold_load, req_err_q;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_wdata;
  logic [NB-1:0]     push_be;

  // Lane placement over a double-width window; the upper half is the high beat.
  always_comb begin
    off = bus.req_addr[OFF_W-1:0];
    d   = '0;
    for (int i = 0; i < NB; i++) begin
      lane_m[i] = (i < (1 << bus.req_size));
      d[8*i +: 8] = lane_m[i] ? bus.req_data[8*i +: 8] : 8'h00;
    end
    s_wide    = {{DATA_W{1'b0}}, d} << {off, 3'b000};
    e_wide    = {{NB{1'b0}}, lane_m} << off;
    need_high = |e_wide[2*NB-1:NB];
    lo_addr   = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    hi_addr   = lo_addr + ADDR_W'(NB);
    reject    = ({1'b0, bus.req_size} > MAX_SIZE) || (need_high && !MISALIGN_SPLIT);
  end

  assign full = (count == FULL_CNT);

  always_comb begin
    state_nxt = state;
    req_rdy   = 1'b0;
    push      = 1'b0;
    push_hold = 1'b0;
    hold_load = 1'b0;
    case (state)
      IDLE: begin
        req_rdy = !full;
        if (bus.req_valid && !full && !reject) begin
          push = 1'b1;
          if (need_high) begin
            hold_load = 1'b1;
            state_nxt = HIGH;
          end
        end
      end
      HIGH: begin
        if (!full) begin
          push      = 1'b1;
          push_hold = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign push_addr  = push_hold ? hold_addr  : lo_addr;
  assign push_wdata = push_hold ? hold_wdata : s_wide[DATA_W-1:0];
  assign push_be    = push_hold ? hold_be    : e_wide[NB-1:0];

  assign bus.req_ready = reset && req_rdy;
  assign acc           = bus.req_valid && bus.req_ready;
  assign bus.mem_valid = reset && (count != '0);
  assign pop           = bus.mem_valid && bus.mem_ready;
  assign bus.req_err   = req_err_q;
  assign bus.mem_addr  = reset ? fifo_addr[rd_ptr]  : '0;
  assign bus.mem_wdata = reset ? fifo_wdata[rd_ptr] : '0;
  assign bus.mem_be    = reset ? fifo_be[rd_ptr]    : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_be    <= '0;
      req_err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr[i]  <= '0;
        fifo_wdata[i] <= '0;
        fifo_be[i]    <= '0;
      end
    end else begin
      state     <= state_nxt;
      req_err_q <= acc && reject;
      if (hold_load) begin
        hold_addr  <= hi_addr;
        hold_wdata <= s_wide[2*DATA_W-1:DATA_W];
        hold_be    <= e_wide[2*NB-1:NB];
      end
      if (push) begin
        fifo_addr[wr_ptr]  <= push_addr;
        fifo_wdata[wr_ptr] <= push_wdata;
        fifo_be[wr_ptr]    <= push_be;
        wr_ptr             <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_store_lane_buffer.sv
// Bench for store_lane_buffer: split instance (bus0) and reject instance (bus1),
// directed scenarios plus random stores against a per-byte reference model.
module tb_store_lane_buffer;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  int   vec = 0;
  int   miscmp = 0;

  beat_t got0[$], got1[$], exp0[$], exp1[$];
  int    err0 = 0, err1 = 0, exp_err0 = 0, exp_err1 = 0;
  bit    rdy_rand = 1'b0;
  bit    rdy_fix  = 1'b0;
  bit    hold0 = 1'b0;
  beat_t prev0;

  store_lane_buffer_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();
  store_lane_buffer_if #(.DATA_W(32), .ADDR_W(32)) bus1 ();

  store_lane_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .MISALIGN_SPLIT(1'b1)) u_split (
    .clk(clk), .reset(reset), .bus(bus0));
  store_lane_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .MISALIGN_SPLIT(1'b0)) u_rej (
    .clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;

  // memory-side ready, applied after request drive so sampling at negedge is race-free
  initial forever begin
    @(posedge clk);
    #2;
    bus0.mem_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
    bus1.mem_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
  end

  // beat/err collection and head stability while stalled
  initial forever begin
    beat_t cur;
    @(negedge clk);
    cur = {bus0.mem_addr, bus0.mem_wdata, bus0.mem_be};
    if (hold0 && reset) begin
      vec++;
      if (!bus0.mem_valid || cur !== prev0) begin
        miscmp++;
        $display("FAIL head_stable: got valid=%b %h want valid=1 %h", bus0.mem_valid, cur, prev0);
      end
    end
    hold0 = reset && bus0.mem_valid && !bus0.mem_ready;
    prev0 = cur;
    if (bus0.mem_valid && bus0.mem_ready) got0.push_back(cur);
    if (bus1.mem_valid && bus1.mem_ready) got1.push_back({bus1.mem_addr, bus1.mem_wdata, bus1.mem_be});
    if (bus0.req_err) err0++;
    if (bus1.req_err) err1++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: place each byte at its own absolute address, group by aligned word.
  task automatic model(input int sel, input logic [31:0] addr, input logic [1:0] size,
                       input logic [31:0] data);
    beat_t b0, b1;
    bit hi;
    logic [31:0] a;
    if (size > 2'd2) begin
      if (sel == 0) exp_err0++; else exp_err1++;
      return;
    end
    b0 = '0; b1 = '0; hi = 1'b0;
    b0.addr = addr & ~32'd3;
    b1.addr = b0.addr + 32'd4;
    for (int k = 0; k < (1 << size); k++) begin
      a = addr + 32'(k);
      if ((a & ~32'd3) == b0.addr) begin
        b0.wdata[8*a[1:0] +: 8] = data[8*k +: 8];
        b0.be[a[1:0]] = 1'b1;
      end else begin
        hi = 1'b1;
        b1.wdata[8*a[1:0] +: 8] = data[8*k +: 8];
        b1.be[a[1:0]] = 1'b1;
      end
    end
    if (hi && sel == 1) begin
      exp_err1++;
    end else begin
      if (sel == 0) exp0.push_back(b0); else exp1.push_back(b0);
      if (hi) begin
        if (sel == 0) exp0.push_back(b1); else exp1.push_back(b1);
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_req(input int sel, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] data, output bit ok);
    bit r;
    ok = 1'b0;
    if (sel == 0) begin
      bus0.req_valid = 1'b1; bus0.req_addr = addr; bus0.req_size = size; bus0.req_data = data;
    end else begin
      bus1.req_valid = 1'b1; bus1.req_addr = addr; bus1.req_size = size; bus1.req_data = data;
    end
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      r = (sel == 0) ? bus0.req_ready : bus1.req_ready;
      @(posedge clk);
      if (r) begin
        ok = 1'b1;
        model(sel, addr, size, data);
      end
    end
    #1;
    bus0.req_valid = 1'b0;
    bus1.req_valid = 1'b0;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    rdy_rand = 1'b0;
    rdy_fix  = 1'b1;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (!bus0.mem_valid && !bus1.mem_valid && bus0.req_ready && bus1.req_ready) ok = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
    err0 = 0; err1 = 0; exp_err0 = 0; exp_err1 = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus0.req_valid = 1'b0; bus1.req_valid = 1'b0;
    bus0.req_addr = '0; bus0.req_size = '0; bus0.req_data = '0;
    bus1.req_addr = '0; bus1.req_size = '0; bus1.req_data = '0;
    bus0.mem_ready = 1'b0; bus1.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec++; if (bus0.req_ready !== 1'b0) begin miscmp++; $display("FAIL rst_ready0: got %b want 0", bus0.req_ready); end
    vec++; if (bus1.req_ready !== 1'b0) begin miscmp++; $display("FAIL rst_ready1: got %b want 0", bus1.req_ready); end
    vec++; if (bus0.mem_valid !== 1'b0) begin miscmp++; $display("FAIL rst_valid: got %b want 0", bus0.mem_valid); end
    vec++; if ({bus0.mem_addr, bus0.mem_wdata, bus0.mem_be} !== 68'h0) begin
      miscmp++; $display("FAIL rst_head: got %h %h %h want 0", bus0.mem_addr, bus0.mem_wdata, bus0.mem_be);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    vec++; if (bus0.req_ready !== 1'b1 || bus1.req_ready !== 1'b1) begin
      miscmp++; $display("FAIL post_rst_ready: got %b%b want 11", bus0.req_ready, bus1.req_ready);
    end
    vec++; if (bus0.mem_valid !== 1'b0 || bus0.req_err !== 1'b0) begin
      miscmp++; $display("FAIL post_rst_idle: got valid=%b err=%b want 0 0", bus0.mem_valid, bus0.req_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_aligned();
    beat_t want[$];
    bit ok, all_ok;
    clear_all();
    rdy_fix = 1'b1;
    send_req(0, 32'h100, 2'd2, 32'hAABBCCDD, all_ok);
    @(negedge clk);
    vec++; if (bus0.mem_valid !== 1'b1) begin miscmp++; $display("FAIL first_latency: got %b want 1", bus0.mem_valid); end
    @(posedge clk); #1;
    send_req(0, 32'h203, 2'd0, 32'h123456EF, ok); all_ok &= ok;
    send_req(0, 32'h011, 2'd1, 32'h00001234, ok); all_ok &= ok;
    drain(ok); all_ok &= ok;
    want.push_back({32'h100, 32'hAABBCCDD, 4'b1111});
    want.push_back({32'h200, 32'hEF000000, 4'b1000});
    want.push_back({32'h010, 32'h00123400, 4'b0110});
    vec++; if (!all_ok) begin miscmp++; $display("FAIL aligned_handshake: got timeout want accepted"); end
    vec++;
    if (got0.size() != want.size()) begin
      miscmp++; $display("FAIL aligned_count: got %0d want %0d", got0.size(), want.size());
    end else foreach (want[i]) begin
      vec++; if (got0[i] !== want[i]) begin miscmp++; $display("FAIL aligned_beat%0d: got %h want %h", i, got0[i], want[i]); end
    end
  endtask

  task automatic test_split();
    beat_t want[$];
    bit ok, all_ok;
    clear_all();
    rdy_fix = 1'b1;
    send_req(0, 32'h102, 2'd2, 32'hAABBCCDD, all_ok);
    @(negedge clk);
    vec++; if (bus0.req_ready !== 1'b0) begin miscmp++; $display("FAIL split_high_ready: got %b want 0", bus0.req_ready); end
    @(posedge clk); #1;
    drain(ok); all_ok &= ok;
    want.push_back({32'h100, 32'hCCDD0000, 4'b1100});
    want.push_back({32'h104, 32'h0000AABB, 4'b0011});
    vec++; if (!all_ok || err0 != 0) begin miscmp++; $display("FAIL split_flow: got ok=%b err=%0d want ok=1 err=0", all_ok, err0); end
    vec++;
    if (got0.size() != want.size()) begin
      miscmp++; $display("FAIL split_count: got %0d want %0d", got0.size(), want.size());
    end else foreach (want[i]) begin
      vec++; if (got0[i] !== want[i]) begin miscmp++; $display("FAIL split_beat%0d: got %h want %h", i, got0[i], want[i]); end
    end
  endtask

  task automatic test_reject();
    bit ok, all_ok;
    clear_all();
    rdy_fix = 1'b1;
    send_req(1, 32'h102, 2'd2, 32'hAABBCCDD, all_ok);
    @(negedge clk);
    vec++; if (bus1.req_err !== 1'b1) begin miscmp++; $display("FAIL rej_err_pulse: got %b want 1", bus1.req_err); end
    vec++; if (bus1.req_ready !== 1'b1) begin miscmp++; $display("FAIL rej_ready: got %b want 1", bus1.req_ready); end
    @(negedge clk);
    vec++; if (bus1.req_err !== 1'b0) begin miscmp++; $display("FAIL rej_err_width: got %b want 0", bus1.req_err); end
    @(posedge clk); #1;
    send_req(1, 32'h040, 2'd3, 32'h11223344, ok); all_ok &= ok;
    @(negedge clk);
    vec++; if (bus1.req_err !== 1'b1) begin miscmp++; $display("FAIL rej_size3: got %b want 1", bus1.req_err); end
    @(posedge clk); #1;
    send_req(0, 32'h040, 2'd3, 32'h11223344, ok); all_ok &= ok;
    drain(ok); all_ok &= ok;
    vec++; if (!all_ok) begin miscmp++; $display("FAIL rej_handshake: got timeout want accepted"); end
    vec++; if (got0.size() != 0 || got1.size() != 0) begin
      miscmp++; $display("FAIL rej_no_beats: got %0d/%0d beats want 0/0", got0.size(), got1.size());
    end
    vec++; if (err0 != 1 || err1 != 2) begin miscmp++; $display("FAIL rej_err_count: got %0d/%0d want 1/2", err0, err1); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] dat[6];
    bit ok, all_ok;
    clear_all();
    rdy_fix = 1'b0;
    all_ok = 1'b1;
    @(posedge clk); #1;
    foreach (dat[i]) dat[i] = $urandom;
    for (int i = 0; i < 4; i++) begin send_req(0, 32'h1000 + 32'(4*i), 2'd2, dat[i], ok); all_ok &= ok; end
    bus0.req_valid = 1'b1; bus0.req_addr = 32'h1010; bus0.req_size = 2'd2; bus0.req_data = dat[4];
    repeat (2) begin
      @(negedge clk);
      vec++; if (bus0.req_ready !== 1'b0) begin miscmp++; $display("FAIL full_ready: got %b want 0", bus0.req_ready); end
      @(posedge clk); #1;
    end
    rdy_fix = 1'b1;
    for (int i = 4; i < 6; i++) begin send_req(0, 32'h1000 + 32'(4*i), 2'd2, dat[i], ok); all_ok &= ok; end
    drain(ok); all_ok &= ok;
    vec++; if (!all_ok) begin miscmp++; $display("FAIL b2b_handshake: got timeout want accepted"); end
    vec++;
    if (got0.size() != 6) begin
      miscmp++; $display("FAIL b2b_count: got %0d want 6", got0.size());
    end else for (int i = 0; i < 6; i++) begin
      vec++;
      if (got0[i] !== {32'h1000 + 32'(4*i), dat[i], 4'hF}) begin
        miscmp++; $display("FAIL b2b_beat%0d: got %h want %h %h f", i, got0[i], 32'h1000 + 32'(4*i), dat[i]);
      end
    end
  endtask

  task automatic test_reset_in_high();
    bit ok, all_ok;
    clear_all();
    rdy_fix = 1'b0;
    all_ok = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin send_req(0, 32'h2000 + 32'(4*i), 2'd2, $urandom, ok); all_ok &= ok; end
    send_req(0, 32'h2016, 2'd2, 32'hDEADBEEF, ok); all_ok &= ok;
    @(negedge clk);
    vec++; if (bus0.req_ready !== 1'b0) begin miscmp++; $display("FAIL high_full_ready: got %b want 0", bus0.req_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    clear_all();
    rdy_fix = 1'b1;
    @(negedge clk);
    vec++; if (bus0.mem_valid !== 1'b0 || bus0.req_ready !== 1'b1) begin
      miscmp++; $display("FAIL rst_high_state: got valid=%b ready=%b want 0 1", bus0.mem_valid, bus0.req_ready);
    end
    repeat (5) @(posedge clk);
    #1;
    vec++; if (got0.size() != 0) begin miscmp++; $display("FAIL rst_high_leak: got %0d beats want 0", got0.size()); end
    send_req(0, 32'h3000, 2'd2, 32'h0BADF00D, ok); all_ok &= ok;
    drain(ok); all_ok &= ok;
    vec++; if (!all_ok) begin miscmp++; $display("FAIL rst_high_handshake: got timeout want accepted"); end
    vec++;
    if (got0.size() != 1 || got0[0] !== {32'h3000, 32'h0BADF00D, 4'hF}) begin
      miscmp++; $display("FAIL rst_high_after: got %0d beats want 1 beat 3000 0badf00d f", got0.size());
    end
  endtask

  task automatic test_random();
    bit ok, all_ok;
    int sel;
    logic [31:0] addr;
    clear_all();
    all_ok = 1'b1;
    rdy_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      sel  = int'($urandom_range(0, 1));
      addr = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7))
                                         : 32'h400 + 32'($urandom_range(0, 63));
      send_req(sel, addr, 2'($urandom_range(0, 3)), $urandom, ok);
      all_ok &= ok;
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    drain(ok); all_ok &= ok;
    vec++; if (!all_ok) begin miscmp++; $display("FAIL rand_handshake: got timeout want accepted"); end
    vec++; if (err0 != exp_err0 || err1 != exp_err1) begin
      miscmp++; $display("FAIL rand_err: got %0d/%0d want %0d/%0d", err0, err1, exp_err0, exp_err1);
    end
    vec++;
    if (got0.size() != exp0.size()) begin
      miscmp++; $display("FAIL rand_count0: got %0d want %0d", got0.size(), exp0.size());
    end else foreach (exp0[i]) begin
      vec++; if (got0[i] !== exp0[i]) begin miscmp++; $display("FAIL rand0_beat%0d: got %h want %h", i, got0[i], exp0[i]); end
    end
    vec++;
    if (got1.size() != exp1.size()) begin
      miscmp++; $display("FAIL rand_count1: got %0d want %0d", got1.size(), exp1.size());
    end else foreach (exp1[i]) begin
      vec++; if (got1[i] !== exp1[i]) begin miscmp++; $display("FAIL rand1_beat%0d: got %h want %h", i, got1[i], exp1[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_split();
    test_reject();
    test_back_to_back();
    test_reset_in_high();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end
endmodule
